// File: rtl/peripheral_dbg_pu_riscv_jtag_driver.sv
// Command-driven JTAG master for the RISC-V debug chain: walks a debug TAP through
// test-logic-reset or a capture/shift/update DR sequence and returns the TDO bits.
module peripheral_dbg_pu_riscv_jtag_driver #(
  parameter int DATAREG_LEN      = 64,
  parameter int MODULE_ID_LENGTH = 2,
  parameter int CLK_DIV          = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_type_i,
  input  logic [6:0]             cmd_len_i,
  input  logic [DATAREG_LEN-1:0] cmd_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATAREG_LEN-1:0] rsp_data_o,
  output logic                   tck_o,
  output logic                   tdi_o,
  input  logic                   tdo_i,
  output logic                   tlr_o,
  output logic                   capture_dr_o,
  output logic                   shift_dr_o,
  output logic                   pause_dr_o,
  output logic                   update_dr_o,
  output logic                   debug_select_o
);

  localparam int PH_W  = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int CNT_W = ($clog2(DATAREG_LEN) > 3) ? $clog2(DATAREG_LEN) : 3;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] TLR_LAST = CNT_W'(4);
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(DATAREG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TLR,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_RESP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PH_W-1:0]        ph;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       last;
  logic [DATAREG_LEN-1:0] sh;
  logic [DATAREG_LEN-1:0] rsp;

  logic                   active;
  logic                   period_end;
  logic                   accept;
  logic [CNT_W-1:0]       len_last;
  logic [DATAREG_LEN-1:0] word;

  assign active     = (state == S_TLR) || (state == S_CAPTURE) ||
                      (state == S_SHIFT) || (state == S_UPDATE);
  assign period_end = (ph == PH_LAST);
  assign accept     = (state == S_IDLE) && cmd_valid_i;
  assign tck_o      = active && (ph >= PH_HIGH);

  // Command decode: effective shift length and the TDI word to send
  always_comb begin
    word = cmd_data_i;
    if (cmd_type_i == 2'd1) begin
      word = '0;
      word[DATAREG_LEN-1] = 1'b1;
      word[DATAREG_LEN-2 -: MODULE_ID_LENGTH] = cmd_data_i[MODULE_ID_LENGTH-1:0];
    end
    if ((cmd_type_i == 2'd1) || (cmd_len_i == 7'd0) || (int'(cmd_len_i) > DATAREG_LEN))
      len_last = LEN_MAX;
    else
      len_last = CNT_W'(cmd_len_i - 7'd1);
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_data_o     = '0;
    tdi_o          = 1'b0;
    tlr_o          = 1'b0;
    capture_dr_o   = 1'b0;
    shift_dr_o     = 1'b0;
    pause_dr_o     = 1'b0;
    update_dr_o    = 1'b0;
    debug_select_o = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i)
          state_nxt = (cmd_type_i == 2'd0) ? S_TLR : S_CAPTURE;
      end
      S_TLR: begin
        tlr_o = 1'b1;
        if (period_end && (cnt == TLR_LAST))
          state_nxt = S_RESP;
      end
      S_CAPTURE: begin
        capture_dr_o   = 1'b1;
        debug_select_o = 1'b1;
        if (period_end)
          state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shift_dr_o     = 1'b1;
        debug_select_o = 1'b1;
        tdi_o          = sh[0];
        if (period_end && (cnt == last))
          state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        update_dr_o    = 1'b1;
        debug_select_o = 1'b1;
        if (period_end)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = rsp;
        if (rsp_ready_i)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: state, TCK phase and period/bit counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      ph    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (!active || period_end)
        ph <= '0;
      else
        ph <= ph + PH_W'(1);
      if (state_nxt != state)
        cnt <= '0;
      else if (active && period_end)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Datapath: TDI shifter and TDO capture (sampled on the last high-phase cycle)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sh   <= word;
      last <= len_last;
      rsp  <= '0;
    end else if ((state == S_SHIFT) && period_end) begin
      rsp[cnt] <= tdo_i;
      sh       <= sh >> 1;
    end
  end

endmodule
